led_controller: RTL and testbench
=================================

// Module: led_controller
// PURPOSE
// - Sequencer for daisy-chained serial LED drivers (TLC5940-style): accepts 32-bit
//   instruction words and produces serial data/shift clock, per-chain latch and grayscale clock.
// - Sits between the command source (CPU or test pattern logic) and the LED driver pins.
// - Exposes its FSM state for debug.
// PARAMETERS
// - DATA_W      16    bits shifted per SHIFT/WRITE, taken from instruction[DATA_W-1:0]
// - SCLK_HALF   1     clk cycles per sclk half-period (>=1)
// - GS_DEFAULT  4096  gsclk pulse count used when instruction count field is 0
// PORTS
// - clk          in   1   system clock, all logic on rising edge
// - rst_n        in   1   synchronous active-low reset
// - instruction  in   32  [31:24] opcode, [19:16] latch mask, [15:0] data/count
// - serial       out  1   serial data to driver chain, MSB first
// - sclk         out  1   shift clock; driver samples serial on sclk rising edge
// - lat          out  4   per-chain latch pulses
// - gsclk        out  1   grayscale clock burst
// - state        out  4   current FSM state code (debug)
// BEHAVIOUR
// - Interface: one clock (clk); reset synchronous, active-low (rst_n).
// - Reset (rst_n=0 at clk edge): state=IDLE(0), serial=0, sclk=0, lat=0, gsclk=0, counters cleared.
// - Opcodes (sampled only in IDLE, nonzero opcode starts op at that edge):
//   0x00 NOP; 0x01 SHIFT; 0x02 LATCH; 0x04 WRITE (SHIFT then LATCH); 0x08 GS burst.
//   Any other opcode is ignored (stay IDLE). Instructions arriving while busy are dropped.
// - Latch mask: instruction[19:16]; mask 0 means all four chains (4'hF). Captured at start.
// - States: IDLE=0, SHIFT_LO=1, SHIFT_HI=2, LATCH=3, GS_HI=4, GS_LO=5, DONE=6.
// - SHIFT_LO: sclk=0, serial=current bit (bit DATA_W-1 first), held SCLK_HALF cycles -> SHIFT_HI.
// - SHIFT_HI: sclk=1, serial unchanged, SCLK_HALF cycles; then next bit -> SHIFT_LO, or after
//   last bit -> LATCH (WRITE) or DONE (SHIFT). One DATA_W word = 2*DATA_W*SCLK_HALF cycles.
// - LATCH: lat=mask for exactly 1 cycle, sclk=0 -> DONE. lat is 0 in every other state.
// - GS: N = count field (0 -> GS_DEFAULT); gsclk=1 in GS_HI, 0 in GS_LO, 1 cycle each;
//   exactly N rising edges of gsclk, 2N cycles, then DONE.
// - DONE: all strobes low for 1 cycle -> IDLE; a new instruction is accepted from IDLE only.
// - serial returns to 0 on leaving SHIFT states; sclk/gsclk idle low.
// - Reset mid-operation aborts immediately to reset values; no partial latch.
// - All outputs are registered (no combinational path from instruction).
// CONFIGURATION
// - LED_CTRL_GS_AUTO_EN defined: after WRITE's LATCH state, FSM enters GS_HI and emits a
//   GS_DEFAULT-pulse gsclk burst before DONE (state codes unchanged).
// - Undefined: WRITE goes LATCH -> DONE; gsclk only via opcode 0x08.
// TESTING
// - Reset: rst_n=0 two edges -> state=0, serial=sclk=gsclk=0, lat=0.
// - instruction=32'h04_00_00_00 for one edge -> 16 sclk pulses with serial=0, then lat=4'hF for
//   1 cycle, DONE, IDLE; total 2*16+1+1 cycles after accept.
// - instruction=32'h01_00_A5_3C -> serial bits 1010_0101_0011_1100 at sclk rising edges, lat stays 0.
// - instruction=32'h02_05_00_00 -> lat=4'b0101 exactly one cycle; 32'h08_00_00_03 -> 3 gsclk pulses.
// - Busy drop: issue 0x01 then 0x02 two cycles later -> only the shift happens; opcode 0x10 ignored.
// - Reset asserted mid-shift -> outputs zero next edge, state=0; GS_AUTO_EN build adds 4096 pulses.

Source files
------------

// File: rtl/led_controller.sv
// Serial LED driver sequencer: shifts words, pulses per-chain latches, bursts gsclk.
// LED_CTRL_GS_AUTO_EN appends a GS_DEFAULT gsclk burst after every WRITE latch.
module led_controller #(
  parameter int DATA_W     = 16,
  parameter int SCLK_HALF  = 1,
  parameter int GS_DEFAULT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic        serial,
  output logic        sclk,
  output logic [3:0]  lat,
  output logic        gsclk,
  output logic [3:0]  state
);

  localparam int HW = $clog2(SCLK_HALF + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int GW = 17;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    SHIFT_LO = 4'd1,
    SHIFT_HI = 4'd2,
    LATCH    = 4'd3,
    GS_HI    = 4'd4,
    GS_LO    = 4'd5,
    DONE     = 4'd6
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic [HW-1:0]       hcnt_q, hcnt_d;
  logic [GW-1:0]       gcnt_q, gcnt_d;
  logic [3:0]          mask_q, mask_d;
  logic                write_q, write_d;

  logic                serial_d;
  logic                sclk_d;
  logic [3:0]          lat_d;
  logic                gsclk_d;

  logic [7:0]          opcode;
  logic [3:0]          mask_in;
  logic [GW-1:0]       gs_n;
  logic                op_shift, op_latch;
  logic                op_write, op_gs;
  logic                half_end;
  logic                unused_bits;

  assign opcode   = instruction[31:24];
  assign mask_in  = (instruction[19:16] == 4'h0)
                  ? 4'hF : instruction[19:16];
  assign gs_n     = (instruction[15:0] == 16'h0)
                  ? GW'(GS_DEFAULT)
                  : {1'b0, instruction[15:0]};
  assign op_shift = (opcode == 8'h01);
  assign op_latch = (opcode == 8'h02);
  assign op_write = (opcode == 8'h04);
  assign op_gs    = (opcode == 8'h08);
  assign half_end = (hcnt_q == HW'(SCLK_HALF - 1));
  assign unused_bits = ^instruction[23:20];

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    hcnt_d  = hcnt_q;
    gcnt_d  = gcnt_q;
    mask_d  = mask_q;
    write_d = write_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          op_shift, op_write: begin
            state_d = SHIFT_LO;
            shreg_d = instruction[DATA_W-1:0];
            bcnt_d  = BW'(DATA_W - 1);
            hcnt_d  = '0;
            mask_d  = mask_in;
            write_d = op_write;
          end
          op_latch: begin
            state_d = LATCH;
            mask_d  = mask_in;
            write_d = 1'b0;
          end
          op_gs: begin
            state_d = GS_HI;
            gcnt_d  = gs_n;
            write_d = 1'b0;
          end
          default: ;
        endcase
      end
      SHIFT_LO: begin
        if (half_end) begin
          hcnt_d  = '0;
          state_d = SHIFT_HI;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      SHIFT_HI: begin
        if (!half_end) begin
          hcnt_d = hcnt_q + HW'(1);
        end else if (bcnt_q == '0) begin
          hcnt_d  = '0;
          state_d = write_q ? LATCH : DONE;
        end else begin
          hcnt_d  = '0;
          bcnt_d  = bcnt_q - BW'(1);
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          state_d = SHIFT_LO;
        end
      end
      LATCH: begin
`ifdef LED_CTRL_GS_AUTO_EN
        if (write_q) begin
          state_d = GS_HI;
          gcnt_d  = GW'(GS_DEFAULT);
        end else begin
          state_d = DONE;
        end
`else
        state_d = DONE;
`endif
      end
      GS_HI: state_d = GS_LO;
      GS_LO: begin
        if (gcnt_q <= GW'(1)) begin
          gcnt_d  = '0;
          state_d = DONE;
        end else begin
          gcnt_d  = gcnt_q - GW'(1);
          state_d = GS_HI;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pins are registered copies of what the next state implies.
  always_comb begin
    serial_d = 1'b0;
    sclk_d   = 1'b0;
    lat_d    = 4'h0;
    gsclk_d  = 1'b0;
    if (state_d == SHIFT_LO || state_d == SHIFT_HI)
      serial_d = shreg_d[DATA_W-1];
    if (state_d == SHIFT_HI)
      sclk_d = 1'b1;
    if (state_d == LATCH)
      lat_d = mask_d;
    if (state_d == GS_HI)
      gsclk_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bcnt_q  <= '0;
      hcnt_q  <= '0;
      gcnt_q  <= '0;
      mask_q  <= '0;
      write_q <= 1'b0;
      serial  <= 1'b0;
      sclk    <= 1'b0;
      lat     <= 4'h0;
      gsclk   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      hcnt_q  <= hcnt_d;
      gcnt_q  <= gcnt_d;
      mask_q  <= mask_d;
      write_q <= write_d;
      serial  <= serial_d;
      sclk    <= sclk_d;
      lat     <= lat_d;
      gsclk   <= gsclk_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_led_controller.sv
// Bench for led_controller: per-cycle pin traces built from the opcode rules.
// Random instructions plus directed reset, busy-drop and abort steps.
module tb_led_controller;

  localparam int DATA_W     = 16;
  localparam int SCLK_HALF  = 1;
  localparam int GS_DEFAULT = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = '0;
  logic        serial;
  logic        sclk;
  logic [3:0]  lat;
  logic        gsclk;
  logic [3:0]  state;

  led_controller #(
    .DATA_W(DATA_W),
    .SCLK_HALF(SCLK_HALF),
    .GS_DEFAULT(GS_DEFAULT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .instruction(instruction),
    .serial(serial),
    .sclk(sclk),
    .lat(lat),
    .gsclk(gsclk),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       ser;
    logic       sck;
    logic [3:0] lt;
    logic       gs;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  function automatic obs_t mk(input int st, input logic ser,
                              input logic sck, input logic [3:0] lt,
                              input logic gs);
    obs_t o;
    o.st  = 4'(st);
    o.ser = ser;
    o.sck = sck;
    o.lt  = lt;
    o.gs  = gs;
    return o;
  endfunction

  task automatic push_gs(input int n);
    for (int p = 0; p < n; p++) begin
      exp_q.push_back(mk(4, 1'b0, 1'b0, 4'h0, 1'b1));
      exp_q.push_back(mk(5, 1'b0, 1'b0, 4'h0, 1'b0));
    end
  endtask

  // Expected pins after each edge, starting with the accepting edge.
  task automatic build(input logic [31:0] ins);
    logic [7:0] op;
    logic [3:0] m;
    int n;
    op = ins[31:24];
    m = (ins[19:16] == 4'h0) ? 4'hF : ins[19:16];
    exp_q.delete();
    if (op == 8'h01 || op == 8'h04) begin
      for (int i = DATA_W - 1; i >= 0; i--) begin
        repeat (SCLK_HALF)
          exp_q.push_back(mk(1, ins[i], 1'b0, 4'h0, 1'b0));
        repeat (SCLK_HALF)
          exp_q.push_back(mk(2, ins[i], 1'b1, 4'h0, 1'b0));
      end
      if (op == 8'h04) begin
        exp_q.push_back(mk(3, 1'b0, 1'b0, m, 1'b0));
`ifdef LED_CTRL_GS_AUTO_EN
        push_gs(GS_DEFAULT);
`endif
      end
      exp_q.push_back(mk(6, 1'b0, 1'b0, 4'h0, 1'b0));
      exp_q.push_back(mk(0, 1'b0, 1'b0, 4'h0, 1'b0));
    end else if (op == 8'h02) begin
      exp_q.push_back(mk(3, 1'b0, 1'b0, m, 1'b0));
      exp_q.push_back(mk(6, 1'b0, 1'b0, 4'h0, 1'b0));
      exp_q.push_back(mk(0, 1'b0, 1'b0, 4'h0, 1'b0));
    end else if (op == 8'h08) begin
      n = (ins[15:0] == 16'h0) ? GS_DEFAULT : int'(ins[15:0]);
      push_gs(n);
      exp_q.push_back(mk(6, 1'b0, 1'b0, 4'h0, 1'b0));
      exp_q.push_back(mk(0, 1'b0, 1'b0, 4'h0, 1'b0));
    end else begin
      exp_q.push_back(mk(0, 1'b0, 1'b0, 4'h0, 1'b0));
    end
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 6))
      0: v[31:24] = 8'h00;
      1: v[31:24] = 8'h01;
      2: v[31:24] = 8'h02;
      3: v[31:24] = 8'h04;
      4: v[31:24] = 8'h08;
      5: v[31:24] = 8'h10;
      default: v[31:24] = 8'($urandom);
    endcase
    if (v[31:24] == 8'h08)
      v[15:0] = 16'($urandom_range(1, 6));
    return v;
  endfunction

  task automatic check(input string tag, input obs_t e);
    obs_t got;
    got = {state, serial, sclk, lat, gsclk};
    total++;
    assert (got === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, e);
    end
  endtask

  // busy_rnd: random words while busy, else busy_ins; abort_at>=0 resets then.
  task automatic run(input logic [31:0] ins, input bit busy_rnd,
                     input logic [31:0] busy_ins, input int abort_at,
                     input string name);
    build(ins);
    @(negedge clk);
    instruction = ins;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0) begin
        @(negedge clk);
        instruction = busy_rnd ? rand_ins() : busy_ins;
      end
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", name, k), exp_q[k]);
      if (k == abort_at) break;
    end
    if (abort_at >= 0) begin
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check({name, "_reset"}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      instruction = '0;
      @(posedge clk);
      #1;
      check({name, "_idle"}, '0);
    end
    @(negedge clk);
    instruction = '0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    instruction = 32'h0100_FFFF;
    @(posedge clk);
    #1;
    check("reset_1", '0);
    @(posedge clk);
    #1;
    check("reset_2", '0);
    @(negedge clk);
    rst_n = 1'b1;
    instruction = '0;
    @(posedge clk);
    #1;
    check("idle_after_reset", '0);

    run(32'h0400_0000, 1'b0, 32'h0, -1, "write_zero");
    run(32'h0100_A53C, 1'b0, 32'h0, -1, "shift_a53c");
    run(32'h0205_0000, 1'b0, 32'h0, -1, "latch_0101");
    run(32'h0800_0003, 1'b0, 32'h0, -1, "gs_3");
    run(32'h0100_1234, 1'b0, 32'h0200_0000, -1, "busy_drop");
    run(32'h10FF_FFFF, 1'b0, 32'h0, -1, "bad_opcode");
    run(32'h040A_C3F0, 1'b1, 32'h0, -1, "write_rnd_busy");
    run(32'h0800_0000, 1'b0, 32'h0, -1, "gs_default");
    run(32'h0100_FFFF, 1'b0, 32'h0, 6, "abort_shift");
    run(32'h0800_0005, 1'b0, 32'h0, 4, "abort_gs");

    for (int r = 0; r < 14; r++)
      run(rand_ins(), 1'b1, 32'h0, -1, $sformatf("rand%0d", r));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
